// File: rtl/winner_aer_pkg.sv
// ============================================================================
// Module  : winner_aer_pkg
// Brief   : Shared defaults and one-hot index helpers for the winner AER path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package winner_aer_pkg;

  localparam int c_width_def = 19;
  localparam int c_depth_def = 4;
  localparam int c_addr_w    = 2;

  function automatic logic is_onehot(input logic [3:0] idx);
    return (idx != 4'd0) && ((idx & (idx - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [c_addr_w-1:0] onehot_to_bin(input logic [3:0] idx);
    logic [c_addr_w-1:0] bin;
    bin = '0;
    case (idx)
      4'b0001: bin = 2'd0;
      4'b0010: bin = 2'd1;
      4'b0100: bin = 2'd2;
      4'b1000: bin = 2'd3;
      default: bin = 2'd0;
    endcase
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aer_fifo.sv
// ============================================================================
// Module  : aer_fifo
// Brief   : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aer_fifo #(
  parameter int p_dw    = 21,
  parameter int p_depth = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [p_dw-1:0]            i_din,
  input  logic                       i_pop,
  output logic [p_dw-1:0]            o_dout,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(p_depth):0]   o_count
);

  localparam int c_pw = $clog2(p_depth);
  localparam int c_cw = c_pw + 1;

  logic [p_dw-1:0] r_mem [p_depth];
  logic [c_pw-1:0] r_wr_ptr;
  logic [c_pw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic            w_valid;

  assign w_valid = (r_count != '0);

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_pw'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_pw'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign o_valid = w_valid;
  assign o_full  = (r_count == c_cw'(p_depth));
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/winner_aer_tx.sv
// ============================================================================
// Module  : winner_aer_tx
// Brief   : Validates one-hot winner strobes and queues them as AER events.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module winner_aer_tx
  import winner_aer_pkg::*;
#(
  parameter int p_width = c_width_def,
  parameter int p_depth = c_depth_def
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_strobe,
  input  logic [3:0]                 i_index,
  input  logic [p_width-1:0]         i_result,
  input  logic                       i_clr,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [c_addr_w-1:0]        o_addr,
  output logic [p_width-1:0]         o_value,
  output logic [$clog2(p_depth):0]   o_count,
  output logic                       o_err,
  output logic [7:0]                 o_drop_cnt
);

  localparam int c_dw = c_addr_w + p_width;

  logic            w_onehot;
  logic            w_multi;
  logic            w_full;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_drop_full;
  logic            w_inc;
  logic [c_dw-1:0] w_dout;
  logic            r_err;
  logic [7:0]      r_drop_cnt;

  assign w_onehot    = is_onehot(i_index);
  assign w_multi     = i_strobe && (i_index != 4'd0) && !w_onehot;
  assign w_pop       = w_valid && i_ready;
  assign w_push      = i_strobe && w_onehot && (!w_full || w_pop);
  assign w_drop_full = i_strobe && w_onehot && w_full && !w_pop;
  assign w_inc       = w_multi || w_drop_full;

  // Clear wins over a same-cycle error or drop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (i_clr) begin
      r_err      <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_multi) r_err <= 1'b1;
      if (w_inc && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  aer_fifo #(
    .p_dw    (c_dw),
    .p_depth (p_depth)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_din   ({onehot_to_bin(i_index), i_result}),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_valid (w_valid),
    .o_full  (w_full),
    .o_count (o_count)
  );

  assign o_valid    = w_valid;
  assign o_addr     = w_dout[c_dw-1 -: c_addr_w];
  assign o_value    = w_dout[p_width-1:0];
  assign o_err      = r_err;
  assign o_drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_winner_aer_tx.sv
// ============================================================================
// Module  : tb_winner_aer_tx
// Brief   : Directed self-checking bench for winner_aer_tx.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_winner_aer_tx;

  localparam int c_w = 19;
  localparam int c_d = 4;

  logic          clk;
  logic          rst;
  logic          strobe;
  logic [3:0]    index;
  logic [c_w-1:0] result;
  logic          clr;
  logic          ready;
  logic          valid;
  logic [1:0]    addr;
  logic [c_w-1:0] value;
  logic [2:0]    count;
  logic          err;
  logic [7:0]    drop_cnt;

  int checks;
  int failures;

  winner_aer_tx #(.p_width(c_w), .p_depth(c_d)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_strobe   (strobe),
    .i_index    (index),
    .i_result   (result),
    .i_clr      (clr),
    .i_ready    (ready),
    .o_valid    (valid),
    .o_addr     (addr),
    .o_value    (value),
    .o_count    (count),
    .o_err      (err),
    .o_drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; strobe = 1'b0; index = 4'd0; result = '0; clr = 1'b0; ready = 1'b0;
    tick(); tick();
    checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (count !== 3'd0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (err !== 1'b0)    begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (addr !== 2'd0 || value !== '0) begin failures++; $display("FAIL reset_data got=%0d/%0d exp=0/0", addr, value); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    strobe = 1'b1; index = 4'b0100; result = 19'd1234; ready = 1'b1;
    tick();
    strobe = 1'b0; index = 4'd0;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", valid); end
    checks++; if (addr !== 2'd2)  begin failures++; $display("FAIL single_addr got=%0d exp=2", addr); end
    checks++; if (value !== 19'd1234) begin failures++; $display("FAIL single_value got=%0d exp=1234", value); end
    tick();
    checks++; if (valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL single_pop got=%b/%0d exp=0/0", valid, count); end
  endtask

  task automatic test_fill_drop();
    logic [3:0] idx_tab [5];
    idx_tab[0] = 4'b0001; idx_tab[1] = 4'b0010; idx_tab[2] = 4'b0100;
    idx_tab[3] = 4'b1000; idx_tab[4] = 4'b0001;
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      strobe = 1'b1; index = idx_tab[k]; result = 19'(100 + k);
      tick();
    end
    strobe = 1'b0; index = 4'd0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL fill_drop got=%0d exp=1", drop_cnt); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fill_err got=%b exp=0", err); end
    tick();
    checks++; if (addr !== 2'd0 || value !== 19'd100) begin failures++; $display("FAIL fill_stable got=%0d/%0d exp=0/100", addr, value); end
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid !== 1'b1 || addr !== 2'(k) || value !== 19'(100 + k)) begin
        failures++; $display("FAIL fill_order%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, valid, addr, value, k, 100 + k);
      end
      tick();
    end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", valid); end
  endtask

  task automatic test_multihot();
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL mh_preclr got=%0d exp=0", drop_cnt); end
    strobe = 1'b1; index = 4'b0110; result = 19'd5;
    tick();
    strobe = 1'b0; index = 4'd0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL mh_err got=%b exp=1", err); end
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL mh_drop got=%0d exp=1", drop_cnt); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL mh_count got=%0d exp=0", count); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (err !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL mh_clr got=%b/%0d exp=0/0", err, drop_cnt); end
    clr = 1'b1; strobe = 1'b1; index = 4'b1111;
    tick();
    clr = 1'b0; strobe = 1'b0; index = 4'd0;
    checks++; if (err !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL mh_clrprio got=%b/%0d exp=0/0", err, drop_cnt); end
  endtask

  task automatic test_full_push_pop();
    logic [3:0] idx_tab [4];
    idx_tab[0] = 4'b0001; idx_tab[1] = 4'b0010; idx_tab[2] = 4'b0100; idx_tab[3] = 4'b1000;
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      strobe = 1'b1; index = idx_tab[k]; result = 19'(200 + k);
      tick();
    end
    strobe = 1'b1; index = 4'b1000; result = 19'd99; ready = 1'b1;
    tick();
    strobe = 1'b0; index = 4'd0; ready = 1'b0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fpp_count got=%0d exp=4", count); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL fpp_drop got=%0d exp=0", drop_cnt); end
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (addr !== 2'(k + 1) || value !== 19'(201 + k)) begin
        failures++; $display("FAIL fpp_order%0d got=%0d/%0d exp=%0d/%0d", k, addr, value, k + 1, 201 + k);
      end
      tick();
    end
    checks++; if (valid !== 1'b1 || addr !== 2'd3 || value !== 19'd99) begin failures++; $display("FAIL fpp_last got=%b/%0d/%0d exp=1/3/99", valid, addr, value); end
    tick();
    ready = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL fpp_drain got=%0d exp=0", count); end
  endtask

  task automatic test_zero_and_saturate();
    strobe = 1'b1; index = 4'd0; result = 19'd7;
    tick();
    strobe = 1'b0;
    checks++; if (valid !== 1'b0 || err !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL zero_idx got=%b/%b/%0d exp=0/0/0", valid, err, drop_cnt); end
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      strobe = 1'b1; index = 4'b0001; result = 19'(300 + k);
      tick();
    end
    for (int k = 0; k < 254; k++) tick();
    strobe = 1'b0;
    checks++; if (drop_cnt !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", drop_cnt); end
    strobe = 1'b1;
    for (int k = 0; k < 46; k++) tick();
    strobe = 1'b0; index = 4'd0;
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", drop_cnt); end
    checks++; if (count !== 3'd4 || err !== 1'b0) begin failures++; $display("FAIL sat_state got=%0d/%b exp=4/0", count, err); end
  endtask

  task automatic test_async_reset();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL ar_pre got=%0d exp=3", count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL ar_now got=%b/%0d exp=0/0", valid, count); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL ar_drop got=%0d exp=0", drop_cnt); end
    #1;
    rst = 1'b0;
    strobe = 1'b1; index = 4'b0010; result = 19'd77;
    tick();
    strobe = 1'b0; index = 4'd0;
    checks++; if (valid !== 1'b1 || addr !== 2'd1 || value !== 19'd77) begin failures++; $display("FAIL ar_first got=%b/%0d/%0d exp=1/1/77", valid, addr, value); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_fill_drop();
    test_multihot();
    test_full_push_pop();
    test_zero_and_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
